// File: rtl/dca_matrix_lsu_pkg.sv
// rtl/dca_matrix_lsu_pkg.sv - shared constants, txn_info layout and FSM encoding for the matrix LSU
package dca_matrix_lsu_pkg;

  // Default configuration of the matrix LSU transaction generators
  localparam int DEF_BW_AXI_ADDR     = 32;
  localparam int DEF_BW_AXI_DATA     = 32;
  localparam int DEF_ELEMENT_BYTES   = 4;
  localparam int DEF_MAX_BURST_BEATS = 16;
  localparam int DEF_BW_NUM_ROW      = 16;
  localparam int DEF_BW_NUM_COL      = 16;
  localparam int DEF_BW_STRIDE       = 16;

  // AXI bursts may not cross a 4KB page
  localparam int BW_4KB_OFFSET = 12;

  // txn_info fields: {is_done, is_last, alen, bitaddr}
  localparam int BW_ALEN         = 8;
  localparam int BW_BURST_BEATS  = BW_ALEN + 1;
  localparam int BW_BITADDR_XTRA = 3;
  localparam int NUM_TXN_FLAGS   = 2;

  // Stride is carried in units of 8 bytes
  localparam int LG_STRIDE_UNIT = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } wtxn_state_e;

endpackage

// File: rtl/dca_burst_split.sv
// rtl/dca_burst_split.sv - combinational AXI burst sizing limited by remaining beats, max burst and 4KB page
module dca_burst_split
  import dca_matrix_lsu_pkg::*;
#(
  parameter int BW_REM          = DEF_BW_NUM_COL + 3,
  parameter int BEAT_BYTES      = DEF_BW_AXI_DATA / 8,
  parameter int MAX_BURST_BEATS = DEF_MAX_BURST_BEATS,
  parameter int LG_BEAT         = $clog2(BEAT_BYTES),
  parameter int BW_PG_OFS       = BW_4KB_OFFSET - LG_BEAT
) (
  input  logic [BW_PG_OFS-1:0]      i_beat_ofs,
  input  logic [BW_REM-1:0]         i_rem_beats,
  output logic [BW_BURST_BEATS-1:0] o_beats,
  output logic [BW_ALEN-1:0]        o_alen,
  output logic                      o_crosses_4kb
);

  // Wide enough to hold the remaining-beat count and a full page of beats
  localparam int W = BW_REM + BW_PG_OFS + 1;

  logic [W-1:0] w_pg_beats;
  logic [W-1:0] w_rem;
  logic [W-1:0] w_cap;

  // Beats left before the next 4KB page boundary (a full page when already aligned)
  assign w_pg_beats = (W'(1) << BW_PG_OFS) - W'(i_beat_ofs);
  assign w_rem      = W'(i_rem_beats);
  assign w_cap      = (w_pg_beats < W'(MAX_BURST_BEATS)) ? w_pg_beats : W'(MAX_BURST_BEATS);

  assign o_beats       = BW_BURST_BEATS'((w_rem < w_cap) ? w_rem : w_cap);
  assign o_alen        = BW_ALEN'(o_beats - BW_BURST_BEATS'(1));
  assign o_crosses_4kb = (w_rem > w_pg_beats);

endmodule

// File: rtl/dca_matrix_lsu_wtxn_gen.sv
// rtl/dca_matrix_lsu_wtxn_gen.sv - matrix LSU write transaction generator, one txn_info per AXI write burst
module dca_matrix_lsu_wtxn_gen
  import dca_matrix_lsu_pkg::*;
#(
  parameter int BW_AXI_ADDR     = DEF_BW_AXI_ADDR,
  parameter int BW_AXI_DATA     = DEF_BW_AXI_DATA,
  parameter int ELEMENT_BYTES   = DEF_ELEMENT_BYTES,
  parameter int MAX_BURST_BEATS = DEF_MAX_BURST_BEATS,
  parameter int BW_NUM_ROW      = DEF_BW_NUM_ROW,
  parameter int BW_NUM_COL      = DEF_BW_NUM_COL,
  parameter int BW_STRIDE       = DEF_BW_STRIDE,
  parameter int BW_TXN_INFO     = BW_AXI_ADDR + BW_BITADDR_XTRA + BW_ALEN + NUM_TXN_FLAGS
) (
  input  logic                   clk,
  input  logic                   rstnn,
  input  logic                   clear,
  input  logic                   inst_valid,
  output logic                   inst_ready,
  input  logic [BW_AXI_ADDR-1:0] inst_addr,
  input  logic [BW_STRIDE-1:0]   inst_stride,
  input  logic [BW_NUM_ROW-1:0]  inst_row_m1,
  input  logic [BW_NUM_COL-1:0]  inst_col_m1,
  output logic                   txn_valid,
  input  logic                   txn_ready,
  output logic [BW_TXN_INFO-1:0] txn_info,
  output logic                   busy
);

  localparam int BEAT_BYTES = BW_AXI_DATA / 8;
  localparam int LG_BEAT    = $clog2(BEAT_BYTES);
  localparam int LG_ELEM    = $clog2(ELEMENT_BYTES);
  localparam int BW_REM     = BW_NUM_COL + 3;
  localparam int BW_PG_OFS  = BW_4KB_OFFSET - LG_BEAT;
  localparam int BW_CB      = BW_NUM_COL + LG_ELEM + 2;

  wtxn_state_e             r_state;
  logic                    r_inst_ready;
  logic                    r_txn_valid;
  logic                    r_busy;
  logic [BW_AXI_ADDR-1:0]  r_row_addr;
  logic [BW_AXI_ADDR-1:0]  r_cur_addr;
  logic [BW_STRIDE-1:0]    r_stride;
  logic [BW_NUM_ROW-1:0]   r_row_m1;
  logic [BW_NUM_ROW-1:0]   r_row_cnt;
  logic [BW_REM-1:0]       r_row_beats;
  logic [BW_REM-1:0]       r_rem_beats;

  logic [BW_CB-1:0]          w_col_bytes;
  logic [BW_CB-1:0]          w_row_beats_wide;
  logic [BW_REM-1:0]         w_row_beats;
  logic [BW_BURST_BEATS-1:0] w_beats;
  logic [BW_ALEN-1:0]        w_alen;
  logic                      w_crosses_4kb;
  logic                      w_row_exhaust;
  logic                      w_last_row;
  logic                      w_is_last;
  logic [BW_AXI_ADDR-1:0]    w_next_cur_addr;
  logic [BW_AXI_ADDR-1:0]    w_next_row_addr;
  logic [BW_TXN_INFO-1:0]    w_txn_info;

  // Beats per row, rounded up to whole beats; only sampled on instruction accept
  assign w_col_bytes      = (BW_CB'(inst_col_m1) + BW_CB'(1)) * BW_CB'(ELEMENT_BYTES);
  assign w_row_beats_wide = (w_col_bytes + BW_CB'(BEAT_BYTES - 1)) >> LG_BEAT;
  assign w_row_beats      = BW_REM'(w_row_beats_wide);

  dca_burst_split #(
    .BW_REM          (BW_REM),
    .BEAT_BYTES      (BEAT_BYTES),
    .MAX_BURST_BEATS (MAX_BURST_BEATS),
    .LG_BEAT         (LG_BEAT),
    .BW_PG_OFS       (BW_PG_OFS)
  ) u_burst_split (
    .i_beat_ofs    (r_cur_addr[BW_4KB_OFFSET-1:LG_BEAT]),
    .i_rem_beats   (r_rem_beats),
    .o_beats       (w_beats),
    .o_alen        (w_alen),
    .o_crosses_4kb (w_crosses_4kb)
  );

  // The burst finishes the row exactly when neither the page nor the max burst cut it short
  assign w_row_exhaust   = ~w_crosses_4kb & (r_rem_beats <= BW_REM'(MAX_BURST_BEATS));
  assign w_last_row      = (r_row_cnt == r_row_m1);
  assign w_is_last       = w_row_exhaust & w_last_row;
  assign w_next_cur_addr = r_cur_addr + (BW_AXI_ADDR'(w_beats) << LG_BEAT);
  assign w_next_row_addr = r_row_addr + (BW_AXI_ADDR'(r_stride) << LG_STRIDE_UNIT);

  // Assemble txn_info from registered state; zero whenever no txn is offered
  always_comb begin
    w_txn_info = '0;
    case (r_state)
      ST_BURST: w_txn_info = {1'b0, w_is_last, w_alen, r_cur_addr, 3'b000};
      ST_DONE:  w_txn_info[BW_TXN_INFO-1] = 1'b1;
      default:  w_txn_info = '0;
    endcase
  end

  // Instruction walk FSM: row-by-row burst generation followed by one done token
  always_ff @(posedge clk) begin
    if (!rstnn) begin
      r_state      <= ST_IDLE;
      r_inst_ready <= 1'b1;
      r_txn_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_row_addr   <= '0;
      r_cur_addr   <= '0;
      r_stride     <= '0;
      r_row_m1     <= '0;
      r_row_cnt    <= '0;
      r_row_beats  <= '0;
      r_rem_beats  <= '0;
    end else if (clear) begin
      r_state      <= ST_IDLE;
      r_inst_ready <= 1'b1;
      r_txn_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (inst_valid) begin
            r_state      <= ST_BURST;
            r_inst_ready <= 1'b0;
            r_txn_valid  <= 1'b1;
            r_busy       <= 1'b1;
            r_row_addr   <= inst_addr;
            r_cur_addr   <= inst_addr;
            r_stride     <= inst_stride;
            r_row_m1     <= inst_row_m1;
            r_row_cnt    <= '0;
            r_row_beats  <= w_row_beats;
            r_rem_beats  <= w_row_beats;
          end
        end
        ST_BURST: begin
          if (txn_ready) begin
            if (w_row_exhaust && w_last_row) begin
              r_state <= ST_DONE;
            end else if (w_row_exhaust) begin
              r_row_addr  <= w_next_row_addr;
              r_cur_addr  <= w_next_row_addr;
              r_row_cnt   <= r_row_cnt + BW_NUM_ROW'(1);
              r_rem_beats <= r_row_beats;
            end else begin
              r_cur_addr  <= w_next_cur_addr;
              r_rem_beats <= r_rem_beats - BW_REM'(w_beats);
            end
          end
        end
        ST_DONE: begin
          if (txn_ready) begin
            r_state      <= ST_IDLE;
            r_inst_ready <= 1'b1;
            r_txn_valid  <= 1'b0;
            r_busy       <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_inst_ready <= 1'b1;
          r_txn_valid  <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign inst_ready = r_inst_ready;
  assign txn_valid  = r_txn_valid;
  assign txn_info   = w_txn_info;
  assign busy       = r_busy;

endmodule
